// File: rtl/gait_pkg.sv
// Shared types and constants for the gait sequencer and its pose ROM.
// GAIT_LOOP_EN (see gait_sequencer) is the only build-time option.
package gait_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_WAIT,
        ST_DWELL,
        ST_HOME
    } state_t;

    localparam logic [7:0] HOME_ANGLE    = 8'd90;
    localparam logic [7:0] MAX_ANGLE     = 8'd180;
    localparam int         SETTLE_CYCLES = 2;

    function automatic logic [7:0] clamp_angle(input logic [7:0] angle);
        return (angle > MAX_ANGLE) ? MAX_ANGLE : angle;
    endfunction

endpackage

// File: rtl/gait_pose_rom.sv
// Combinational keyframe table: pose index -> raw joint angles, joint j in bits [8j+7:8j].
// Joints beyond the fourth reuse the column of joint (j mod 4).
module gait_pose_rom #(
    parameter int N_JOINTS = 4
) (
    input  logic [3:0]            pose,
    output logic [8*N_JOINTS-1:0] angles
);

    logic [31:0] row;

    // Rows are packed {joint3, joint2, joint1, joint0}; some entries exceed 180 on purpose.
    always_comb begin
        case (pose)
            4'd0:    row = 32'h5A783C5A;
            4'd1:    row = 32'h50823264;
            4'd2:    row = 32'h468C286E;
            4'd3:    row = 32'h3C96C878;
            4'd4:    row = 32'h32B51E82;
            4'd5:    row = 32'h3C962878;
            4'd6:    row = 32'h468C326E;
            4'd7:    row = 32'h5082B464;
            default: row = 32'h5A5A5A5A;
        endcase
    end

    for (genvar j = 0; j < N_JOINTS; j++) begin : g_joint
        assign angles[8*j +: 8] = row[8*(j % 4) +: 8];
    end

endmodule

// File: rtl/gait_sequencer.sv
// Steps a set of joint ramp units through a keyframe gait with settle, dwell and watchdog.
// Define GAIT_LOOP_EN to wrap from the last pose back to pose 0 instead of homing after one pass.
module gait_sequencer
    import gait_pkg::*;
#(
    parameter int N_JOINTS  = 4,
    parameter int N_POSES   = 8,
    parameter int DWELL_W   = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iStart,
    input  logic                  iStop,
    input  logic [DWELL_W-1:0]    iDwell,
    input  logic [N_JOINTS-1:0]   iDone,
    output logic [8*N_JOINTS-1:0] oAngle,
    output logic [3:0]            oPose,
    output logic                  oBusy,
    output logic                  oStep,
    output logic                  oFault
);

    localparam logic [3:0]            LAST_POSE   = 4'(N_POSES - 1);
    localparam logic [1:0]            SETTLE_LAST = 2'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0]  WD_LAST     = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [8*N_JOINTS-1:0] HOME_VEC    = {N_JOINTS{HOME_ANGLE}};

    state_t                 state;
    logic [1:0]             settle_cnt;
    logic [DWELL_W-1:0]     dwell_cnt;
    logic [TIMEOUT_W-1:0]   wd_cnt;
    logic                   stop_latch;
    logic                   homing;
    logic [8*N_JOINTS-1:0]  rom_angle;
    logic [8*N_JOINTS-1:0]  load_angle;

    gait_pose_rom #(
        .N_JOINTS (N_JOINTS)
    ) u_rom (
        .pose   (oPose),
        .angles (rom_angle)
    );

    always_comb begin
        load_angle = '0;
        for (int j = 0; j < N_JOINTS; j++) begin
            load_angle[8*j +: 8] = clamp_angle(rom_angle[8*j +: 8]);
        end
    end

    assign oBusy = (state != ST_IDLE);

    // The homing move reuses SETTLE/WAIT; 'homing' tells WAIT to finish in IDLE instead of DWELL.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= ST_IDLE;
            oAngle     <= HOME_VEC;
            oPose      <= '0;
            oStep      <= 1'b0;
            oFault     <= 1'b0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            wd_cnt     <= '0;
            stop_latch <= 1'b0;
            homing     <= 1'b0;
        end else begin
            oStep <= 1'b0;
            if (iStop && state != ST_IDLE) begin
                stop_latch <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (iStart && !iStop && !oFault) begin
                        oPose <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    oAngle     <= load_angle;
                    oStep      <= 1'b1;
                    settle_cnt <= '0;
                    wd_cnt     <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_WAIT;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ST_WAIT: begin
                    if (&iDone) begin
                        if (homing) begin
                            homing     <= 1'b0;
                            stop_latch <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            dwell_cnt <= '0;
                            state     <= ST_DWELL;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        oFault <= 1'b1;
                        wd_cnt <= '1;
                        if (homing) begin
                            homing     <= 1'b0;
                            stop_latch <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_HOME;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt >= iDwell) begin
                        if (stop_latch || iStop) begin
                            state <= ST_HOME;
                        end else if (oPose == LAST_POSE) begin
`ifdef GAIT_LOOP_EN
                            oPose <= '0;
                            state <= ST_LOAD;
`else
                            state <= ST_HOME;
`endif
                        end else begin
                            oPose <= oPose + 4'd1;
                            state <= ST_LOAD;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                ST_HOME: begin
                    oAngle     <= HOME_VEC;
                    oPose      <= '0;
                    homing     <= 1'b1;
                    settle_cnt <= '0;
                    wd_cnt     <= '0;
                    state      <= ST_SETTLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gait_sequencer.sv
// Directed bench for gait_sequencer: timing, pose order, clamping, stop, watchdog and reset.
// Ramp units are modelled as raising iDone 20 cycles after each oStep.
module tb_gait_sequencer;

    localparam int NJ = 4;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam logic [31:0] HOME32 = 32'h5A5A5A5A;

    logic          iClk   = 1'b0;
    logic          iRst_n = 1'b0;
    logic          iStart = 1'b0;
    logic          iStop  = 1'b0;
    logic [DW-1:0] iDwell = 16'd3;
    logic [NJ-1:0] iDone;
    logic [31:0]   oAngle;
    logic [3:0]    oPose;
    logic          oBusy;
    logic          oStep;
    logic          oFault;

    logic          modelEn    = 1'b1;
    logic [NJ-1:0] modelDone  = '1;
    logic [NJ-1:0] forcedDone = '0;
    int            modelCnt   = 20;
    int            cyc        = 0;
    int            checks     = 0;
    int            errors     = 0;

    int            stepCyc[$];
    int            stepPose[$];
    logic [31:0]   stepAngle[$];

    logic [31:0] expAngle [0:7] = '{32'h5A783C5A, 32'h50823264, 32'h468C286E, 32'h3C96B478,
                                    32'h32B41E82, 32'h3C962878, 32'h468C326E, 32'h5082B464};

    assign iDone = modelEn ? modelDone : forcedDone;

    gait_sequencer #(
        .N_JOINTS  (NJ),
        .N_POSES   (8),
        .DWELL_W   (DW),
        .TIMEOUT_W (TW)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iStart (iStart),
        .iStop  (iStop),
        .iDwell (iDwell),
        .iDone  (iDone),
        .oAngle (oAngle),
        .oPose  (oPose),
        .oBusy  (oBusy),
        .oStep  (oStep),
        .oFault (oFault)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oStep === 1'b1) begin
            stepCyc.push_back(cyc);
            stepPose.push_back(int'(oPose));
            stepAngle.push_back(oAngle);
        end
    end

    always @(negedge iClk) begin
        if (oStep === 1'b1) begin
            modelCnt  = 0;
            modelDone = '0;
        end else if (modelCnt < 20) begin
            modelCnt++;
            if (modelCnt == 20) modelDone = '1;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout simulation did not finish (checks=%0d)", checks);
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic pulse_stop();
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
    endtask

    task automatic wait_steps(input int target, input int bound, output bit ok);
        int n = 0;
        while (stepCyc.size() < target && n < bound) begin
            tick();
            n++;
        end
        ok = (stepCyc.size() >= target);
    endtask

    task automatic wait_idle(input int bound, output bit ok, output int idleCyc);
        int n = 0;
        while (oBusy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        ok      = (oBusy === 1'b0);
        idleCyc = cyc;
    endtask

    task automatic test_reset();
        int  base;
        bit  busySeen = 1'b0;
        iRst_n = 1'b0;
        tick();
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL reset_angle got %h want %h", oAngle, HOME32); end
        checks++; if (oPose !== 4'd0) begin errors++; $display("[TB] FAIL reset_pose got %0d want 0", oPose); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", oBusy); end
        checks++; if (oStep !== 1'b0) begin errors++; $display("[TB] FAIL reset_step got %b want 0", oStep); end
        checks++; if (oFault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %b want 0", oFault); end
        iRst_n = 1'b1;
        base = stepCyc.size();
        repeat (10) begin
            tick();
            if (oBusy !== 1'b0) busySeen = 1'b1;
        end
        checks++; if (busySeen) begin errors++; $display("[TB] FAIL idle_busy got 1 want 0"); end
        checks++; if (stepCyc.size() != base) begin errors++; $display("[TB] FAIL idle_step got %0d pulses want 0", stepCyc.size() - base); end
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL idle_angle got %h want %h", oAngle, HOME32); end
    endtask

    task automatic test_start_stop_together();
        int base = stepCyc.size();
        bit busySeen = 1'b0;
        iStart = 1'b1;
        iStop  = 1'b1;
        repeat (5) begin
            tick();
            if (oBusy !== 1'b0) busySeen = 1'b1;
        end
        iStart = 1'b0;
        iStop  = 1'b0;
        tick();
        checks++; if (busySeen) begin errors++; $display("[TB] FAIL start_stop_busy got 1 want 0"); end
        checks++; if (stepCyc.size() != base) begin errors++; $display("[TB] FAIL start_stop_step got %0d want 0", stepCyc.size() - base); end
    endtask

    task automatic test_gait_sequence();
        int base = stepCyc.size();
        int idleCyc;
        bit ok;
        iDwell = 16'd3;
        pulse_start();
        wait_steps(base + 3, 200, ok);
        pulse_start();
        wait_steps(base + 8, 400, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL gait_steps got %0d want 8", stepCyc.size() - base); end
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (stepPose[base+i] != i) begin errors++; $display("[TB] FAIL gait_pose[%0d] got %0d want %0d", i, stepPose[base+i], i); end
                checks++; if (stepAngle[base+i] !== expAngle[i]) begin errors++; $display("[TB] FAIL gait_angle[%0d] got %h want %h", i, stepAngle[base+i], expAngle[i]); end
                if (i > 0) begin
                    checks++; if (stepCyc[base+i] - stepCyc[base+i-1] != 26) begin errors++; $display("[TB] FAIL gait_spacing[%0d] got %0d want 26", i, stepCyc[base+i] - stepCyc[base+i-1]); end
                end
            end
        end
`ifdef GAIT_LOOP_EN
        wait_steps(base + 9, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL loop_wrap got %0d steps want 9", stepCyc.size() - base); end
        if (ok) begin
            checks++; if (stepPose[base+8] != 0) begin errors++; $display("[TB] FAIL loop_pose got %0d want 0", stepPose[base+8]); end
            checks++; if (stepCyc[base+8] - stepCyc[base+7] != 26) begin errors++; $display("[TB] FAIL loop_spacing got %0d want 26", stepCyc[base+8] - stepCyc[base+7]); end
        end
        pulse_stop();
        wait_idle(200, ok, idleCyc);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL loop_stop_idle busy got %b want 0", oBusy); end
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL loop_home_angle got %h want %h", oAngle, HOME32); end
`else
        wait_idle(100, ok, idleCyc);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_idle busy got %b want 0", oBusy); end
        if (ok && stepCyc.size() >= base + 8) begin
            checks++; if (idleCyc - stepCyc[base+7] != 29) begin errors++; $display("[TB] FAIL single_idle_time got %0d want 29", idleCyc - stepCyc[base+7]); end
        end
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL single_home_angle got %h want %h", oAngle, HOME32); end
        checks++; if (oPose !== 4'd0) begin errors++; $display("[TB] FAIL single_home_pose got %0d want 0", oPose); end
        checks++; if (stepCyc.size() != base + 8) begin errors++; $display("[TB] FAIL single_step_count got %0d want 8", stepCyc.size() - base); end
`endif
    endtask

    task automatic test_dwell_zero();
        int base = stepCyc.size();
        int idleCyc;
        bit ok;
        iDwell = 16'd0;
        pulse_start();
        wait_steps(base + 2, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL dwell0_steps got %0d want 2", stepCyc.size() - base); end
        if (ok) begin
            checks++; if (stepCyc[base+1] - stepCyc[base] != 23) begin errors++; $display("[TB] FAIL dwell0_spacing got %0d want 23", stepCyc[base+1] - stepCyc[base]); end
            checks++; if (stepPose[base+1] != 1) begin errors++; $display("[TB] FAIL dwell0_pose got %0d want 1", stepPose[base+1]); end
        end
        pulse_stop();
        wait_idle(100, ok, idleCyc);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL dwell0_idle busy got %b want 0", oBusy); end
        iDwell = 16'd3;
    endtask

    task automatic test_stop_mid_gait();
        int base = stepCyc.size();
        int homeCyc = -1;
        int idleCyc = -1;
        int n = 0;
        bit ok;
        pulse_start();
        wait_steps(base + 6, 300, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stop_reach_pose5 got %0d steps want 6", stepCyc.size() - base); end
        if (ok) begin
            checks++; if (stepPose[base+5] != 5) begin errors++; $display("[TB] FAIL stop_pose5 got %0d want 5", stepPose[base+5]); end
        end
        repeat (5) tick();
        pulse_stop();
        while (oBusy !== 1'b0 && n < 100) begin
            if (homeCyc < 0 && oAngle === HOME32) homeCyc = cyc;
            tick();
            n++;
        end
        if (oBusy === 1'b0) idleCyc = cyc;
        checks++; if (idleCyc < 0) begin errors++; $display("[TB] FAIL stop_idle busy got %b want 0", oBusy); end
        if (ok && idleCyc >= 0) begin
            checks++; if (homeCyc - stepCyc[base+5] != 26) begin errors++; $display("[TB] FAIL stop_home_time got %0d want 26", homeCyc - stepCyc[base+5]); end
            checks++; if (idleCyc - stepCyc[base+5] != 29) begin errors++; $display("[TB] FAIL stop_idle_time got %0d want 29", idleCyc - stepCyc[base+5]); end
        end
        checks++; if (stepCyc.size() != base + 6) begin errors++; $display("[TB] FAIL stop_extra_steps got %0d want 6", stepCyc.size() - base); end
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL stop_home_angle got %h want %h", oAngle, HOME32); end
        checks++; if (oPose !== 4'd0) begin errors++; $display("[TB] FAIL stop_home_pose got %0d want 0", oPose); end
    endtask

    task automatic test_reset_mid_gait();
        int base = stepCyc.size();
        bit ok;
        pulse_start();
        wait_steps(base + 3, 200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_reach got %0d steps want 3", stepCyc.size() - base); end
        repeat (4) tick();
        #2;
        iRst_n = 1'b0;
        #1;
        checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", oBusy); end
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL rstmid_angle got %h want %h", oAngle, HOME32); end
        checks++; if (oPose !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_pose got %0d want 0", oPose); end
        tick();
        iRst_n = 1'b1;
        base = stepCyc.size();
        repeat (5) tick();
        checks++; if (stepCyc.size() != base || oBusy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_home got busy %b steps %0d want 0 0", oBusy, stepCyc.size() - base); end
    endtask

    task automatic test_watchdog();
        int base = stepCyc.size();
        int faultCyc = -1;
        int idleCyc;
        int n = 0;
        bit ok;
        modelEn    = 1'b0;
        forcedDone = '0;
        pulse_start();
        while (oFault !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (oFault === 1'b1) faultCyc = cyc;
        checks++; if (faultCyc < 0) begin errors++; $display("[TB] FAIL wd_fault got %b want 1", oFault); end
        if (faultCyc >= 0 && stepCyc.size() > base) begin
            checks++; if (faultCyc - stepCyc[base] != 257) begin errors++; $display("[TB] FAIL wd_time got %0d want 257", faultCyc - stepCyc[base]); end
            checks++; if (stepAngle[base] !== expAngle[0]) begin errors++; $display("[TB] FAIL wd_load_angle got %h want %h", stepAngle[base], expAngle[0]); end
        end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("[TB] FAIL wd_busy_at_fault got %b want 1", oBusy); end
        wait_idle(400, ok, idleCyc);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL wd_idle busy got %b want 0", oBusy); end
        checks++; if (oAngle !== HOME32) begin errors++; $display("[TB] FAIL wd_home_angle got %h want %h", oAngle, HOME32); end
        checks++; if (oFault !== 1'b1) begin errors++; $display("[TB] FAIL wd_sticky got %b want 1", oFault); end
        modelEn = 1'b1;
        base = stepCyc.size();
        pulse_start();
        repeat (5) tick();
        checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL wd_start_blocked busy got %b want 0", oBusy); end
        checks++; if (stepCyc.size() != base) begin errors++; $display("[TB] FAIL wd_start_blocked steps got %0d want 0", stepCyc.size() - base); end
    endtask

    task automatic test_fault_clear();
        int base;
        int idleCyc;
        bit ok;
        iRst_n = 1'b0;
        tick();
        checks++; if (oFault !== 1'b0) begin errors++; $display("[TB] FAIL fault_clear got %b want 0", oFault); end
        iRst_n = 1'b1;
        tick();
        base = stepCyc.size();
        pulse_start();
        wait_steps(base + 1, 20, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL fault_restart steps got %0d want 1", stepCyc.size() - base); end
        pulse_stop();
        wait_idle(100, ok, idleCyc);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL fault_restart_idle busy got %b want 0", oBusy); end
    endtask

    initial begin
        test_reset();
        test_start_stop_together();
        test_gait_sequence();
        test_dwell_zero();
        test_stop_mid_gait();
        test_reset_mid_gait();
        test_watchdog();
        test_fault_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gait_sequencer.md
GAIT_SEQUENCER -- requirements
Module: gait_sequencer

Interface
REQ-001 Parameter N_JOINTS, default 4: number of joint ramp units driven.
REQ-002 Parameter N_POSES, default 8: keyframes per gait cycle, 2..16.
REQ-003 Parameter DWELL_W, default 16: width of dwell counter and iDwell.
REQ-004 Parameter TIMEOUT_W, default 24: width of the settle watchdog counter.
REQ-005 iClk  input  1  system clock, all logic on rising edge.
REQ-006 iRst_n  input  1  asynchronous, active-low reset.
REQ-007 iStart  input  1  level; begin gait from pose 0 when idle.
REQ-008 iStop  input  1  level; request orderly stop.
REQ-009 iDwell  input  DWELL_W  hold cycles after all joints reach a pose.
REQ-010 iDone  input  N_JOINTS  per-joint "at target" flag from ramp units, 1 = output angle equals target.
REQ-011 oAngle  output  8*N_JOINTS  target angles; joint j at bits [8j+7:8j], registered.
REQ-012 oPose  output  4  index of pose currently commanded, registered.
REQ-013 oBusy  output  1  high in every state except IDLE.
REQ-014 oStep  output  1  one-cycle pulse on each new pose load.
REQ-015 oFault  output  1  sticky; watchdog expired.

Function
REQ-016 FSM states: IDLE, LOAD, SETTLE, WAIT, DWELL, HOME.
REQ-017 IDLE: iStart=1 and iStop=0 -> LOAD with pose 0; iStart and iStop both 1 -> stay IDLE.
REQ-018 LOAD (1 cycle): oAngle <= table[oPose], each angle clamped to 180 if >180; oStep=1; -> SETTLE.
REQ-019 SETTLE: ignore iDone for exactly 2 cycles (ramp flag lag), then -> WAIT.
REQ-020 WAIT: when iDone all ones -> DWELL with dwell counter cleared; else increment watchdog.
REQ-021 Watchdog reaching all ones in WAIT: set oFault, -> HOME.
REQ-022 DWELL: count to iDwell cycles (iDwell=0 -> exactly 1 DWELL cycle); then if stop latched -> HOME, else advance pose.
REQ-023 Pose advance: oPose+1; from N_POSES-1 behaviour per REQ-031/032.
REQ-024 iStop=1 in any busy state sets a stop latch; current pose completes through WAIT and DWELL before HOME.
REQ-025 HOME: oAngle <= 90 all joints, oPose <= 0, pass through SETTLE/WAIT semantics, then -> IDLE, stop latch cleared.
REQ-026 Watchdog expiry during HOME: oFault set, -> IDLE anyway.
REQ-027 iStart while busy ignored; oFault cleared only by reset.
REQ-028 oFault=1 blocks IDLE->LOAD.

Reset
REQ-029 On iRst_n low: state IDLE, oAngle all joints 8'd90, oPose 0, oBusy 0, oStep 0, oFault 0, counters and stop latch 0.
REQ-030 Reset mid-gait takes effect immediately, no HOME sequence.

Configuration
REQ-031 GAIT_LOOP_EN defined: after pose N_POSES-1 wrap to pose 0 and continue until stop.
REQ-032 GAIT_LOOP_EN undefined: after pose N_POSES-1 DWELL -> HOME (single pass).

Structure
REQ-033 Package gait_pkg: state enum, HOME_ANGLE=90, MAX_ANGLE=180, SETTLE_CYCLES=2.
REQ-034 Sub-module gait_pose_rom: combinational pose index -> N_JOINTS*8 angle lookup.

Verification
REQ-035 Reset, then idle 10 cycles -> oAngle all 0x5A, oBusy 0, oStep never pulses.
REQ-036 iStart, iDwell=3, model iDone rising 20 cycles after each load -> oStep per pose, 2+20+4-cycle spacing, pose 0..7 order.
REQ-037 GAIT_LOOP_EN, iStop asserted during pose 5 WAIT -> pose 5 completes, HOME loads 90s, IDLE.
REQ-038 No GAIT_LOOP_EN -> after pose 7 returns HOME then IDLE without iStop.
REQ-039 iDone held 0, TIMEOUT_W=8 -> oFault after 255 WAIT cycles, HOME, IDLE; later iStart ignored.
REQ-040 ROM entry 200 -> oAngle field 180; iStart+iStop together in IDLE -> stays IDLE.
